// File: rtl/ssd1306_spi_tx.sv
// Byte-wide SPI mode-0 transmitter for the SSD1306 OLED: one byte per start/ready
// handshake, MSB first, with chip-select framing closed by the last-byte flag.
module ssd1306_spi_tx #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic       clk_in,
    input  logic       resetn_in,
    input  logic       start_in,
    input  logic [7:0] data_in,
    input  logic       last_byte_in,
    output logic       ready_out,
    output logic       oled_sclk,
    output logic       oled_sdin,
    output logic       oled_csn
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOW  = 3'd1,
        S_HIGH = 3'd2,
        S_END  = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t     state_q, state_nxt;
    logic [7:0] div_q, div_nxt;
    logic [2:0] bit_cnt_q, bit_cnt_nxt;
    logic [7:0] shift_q, shift_nxt;
    logic       last_q, last_nxt;
    logic       ready_nxt, sclk_nxt, sdin_nxt, csn_nxt;
    logic       accept;
    logic       phase_done;

    // ready_out is only ever high in IDLE, so it alone qualifies the handshake.
    assign accept     = start_in && ready_out;
    assign phase_done = (div_q == DIV_LAST);

    always_ff @(posedge clk_in or negedge resetn_in) begin
        if (!resetn_in) begin
            state_q   <= S_IDLE;
            div_q     <= 8'd0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'd0;
            last_q    <= 1'b0;
            ready_out <= 1'b1;
            oled_sclk <= 1'b0;
            oled_sdin <= 1'b0;
            oled_csn  <= 1'b1;
        end else begin
            state_q   <= state_nxt;
            div_q     <= div_nxt;
            bit_cnt_q <= bit_cnt_nxt;
            shift_q   <= shift_nxt;
            last_q    <= last_nxt;
            ready_out <= ready_nxt;
            oled_sclk <= sclk_nxt;
            oled_sdin <= sdin_nxt;
            oled_csn  <= csn_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE: if (accept) state_nxt = S_LOW;
            S_LOW:  if (phase_done) state_nxt = S_HIGH;
            S_HIGH: if (phase_done) state_nxt = (bit_cnt_q == 3'd0) ? S_END : S_LOW;
            S_END: begin
                if (!last_q) state_nxt = S_IDLE;
                else if (phase_done) state_nxt = S_GAP;
            end
            S_GAP:  if (phase_done) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bit_cnt_nxt = bit_cnt_q;
        shift_nxt   = shift_q;
        last_nxt    = last_q;
        ready_nxt   = ready_out;
        sclk_nxt    = oled_sclk;
        sdin_nxt    = oled_sdin;
        csn_nxt     = oled_csn;
        // The divider restarts on every phase change so each phase lasts exactly CLK_DIV cycles.
        if ((state_nxt != state_q) || (state_q == S_IDLE)) begin
            div_nxt = 8'd0;
        end else begin
            div_nxt = div_q + 8'd1;
        end
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    shift_nxt   = data_in;
                    last_nxt    = last_byte_in;
                    ready_nxt   = 1'b0;
                    csn_nxt     = 1'b0;
                    sdin_nxt    = data_in[7];
                    bit_cnt_nxt = 3'd7;
                end
            end
            S_LOW: begin
                if (phase_done) sclk_nxt = 1'b1;
            end
            S_HIGH: begin
                if (phase_done) begin
                    sclk_nxt = 1'b0;
                    if (bit_cnt_q != 3'd0) begin
                        shift_nxt   = {shift_q[6:0], 1'b0};
                        sdin_nxt    = shift_q[6];
                        bit_cnt_nxt = bit_cnt_q - 3'd1;
                    end
                end
            end
            S_END: begin
                if (!last_q) ready_nxt = 1'b1;
                else if (phase_done) csn_nxt = 1'b1;
            end
            S_GAP: begin
                if (phase_done) ready_nxt = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ssd1306_spi_tx.sv
// Bench for ssd1306_spi_tx: a CLK_DIV=2 instance exercised by a vector table and
// hand-written corner sequences, plus a CLK_DIV=1 instance for the fastest clock.
module tb_ssd1306_spi_tx;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn;
    logic       start, last;
    logic [7:0] data;
    logic       ready, sclk, sdin, csn;
    logic       start1, last1;
    logic [7:0] data1;
    logic       ready1, sclk1, sdin1, csn1;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ssd1306_spi_tx #(.CLK_DIV(2)) u_dut (
        .clk_in(clk), .resetn_in(resetn), .start_in(start), .data_in(data),
        .last_byte_in(last), .ready_out(ready), .oled_sclk(sclk),
        .oled_sdin(sdin), .oled_csn(csn)
    );

    ssd1306_spi_tx #(.CLK_DIV(1)) u_dut1 (
        .clk_in(clk), .resetn_in(resetn), .start_in(start1), .data_in(data1),
        .last_byte_in(last1), .ready_out(ready1), .oled_sclk(sclk1),
        .oled_sdin(sdin1), .oled_csn(csn1)
    );

    // ---------------- scoreboard ----------------
    int tests_run = 0;
    int tests_failed = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp1_q[$];

    function automatic void check(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, actual, actual, expected, expected, cyc);
        end
    endfunction

    function automatic void fail_now(input string name);
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL %s at cycle %0d", name, cyc);
    endfunction

    // Monitor for the CLK_DIV=2 instance: shifts in SDIN on each SCLK rise.
    logic [7:0] mon_sr = 8'd0;
    int         mon_n = 0;
    logic       mon_prev_sclk = 1'b0;
    logic       mon_prev_csn = 1'b1;
    int         bytes_seen = 0;
    int         csn_rises = 0;

    always @(negedge clk) begin
        if (!resetn) begin
            mon_n = 0;
            mon_prev_sclk = 1'b0;
            mon_prev_csn = 1'b1;
        end else begin
            if (csn && !mon_prev_csn) csn_rises++;
            if (sclk && !mon_prev_sclk) begin
                check("csn_low_at_rise", int'(csn), 0);
                mon_sr = {mon_sr[6:0], sdin};
                mon_n++;
                if (mon_n == 8) begin
                    mon_n = 0;
                    bytes_seen++;
                    if (exp_q.size() == 0) fail_now("unexpected_byte");
                    else check("byte", int'(mon_sr), int'(exp_q.pop_front()));
                end
            end
            mon_prev_sclk = sclk;
            mon_prev_csn = csn;
        end
    end

    // Monitor for the CLK_DIV=1 instance.
    logic [7:0] mon1_sr = 8'd0;
    int         mon1_n = 0;
    logic       mon1_prev_sclk = 1'b0;

    always @(negedge clk) begin
        if (!resetn) begin
            mon1_n = 0;
            mon1_prev_sclk = 1'b0;
        end else begin
            if (sclk1 && !mon1_prev_sclk) begin
                mon1_sr = {mon1_sr[6:0], sdin1};
                mon1_n++;
                if (mon1_n == 8) begin
                    mon1_n = 0;
                    if (exp1_q.size() == 0) fail_now("unexpected_byte_div1");
                    else check("byte_div1", int'(mon1_sr), int'(exp1_q.pop_front()));
                end
            end
            mon1_prev_sclk = sclk1;
        end
    end

    // ---------------- driver tasks (called at a falling clock edge) ----------------
    task automatic accept_byte(input logic [7:0] d, input logic l, output int acc);
        int n;
        n = 0;
        while (!ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) fail_now("ready_timeout");
        data  = d;
        last  = l;
        start = 1'b1;
        exp_q.push_back(d);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        acc = cyc;
    endtask

    // Edge numbers below are relative to the accept edge (edge 0).
    task automatic run_to_ready(input int acc, output int rise1, output int csn_e,
                                output int rdy_e, output int rises);
        logic p;
        p = sclk;
        rise1 = -1;
        csn_e = -1;
        rdy_e = -1;
        rises = 0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (sclk && !p) begin
                rises++;
                if (rise1 < 0) rise1 = cyc - acc;
            end
            p = sclk;
            if (csn && csn_e < 0) csn_e = cyc - acc;
            if (ready) begin
                rdy_e = cyc - acc;
                break;
            end
        end
        if (rdy_e < 0) fail_now("run_to_ready_timeout");
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        logic [7:0] data;
        logic       last;
        int         exp_rise1;
        int         exp_csn;
        int         exp_rdy;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } rom_t;

    vec_t vecs[6];
    rom_t rom[8];

    initial begin
        int acc, prev_acc, rise1, csn_e, rdy_e, rises, b0, r0, e, rdy1;
        logic prev_last;
        logic p;

        // CLK_DIV=2: rise at D, CS high at 17D, ready at 18D (last) or 16D+1.
        vecs[0] = '{8'hA5, 1'b1, 2, 34, 36};
        vecs[1] = '{8'h81, 1'b0, 2, -1, 33};
        vecs[2] = '{8'h7F, 1'b1, 2, 34, 36};
        vecs[3] = '{8'h00, 1'b0, 2, -1, 33};
        vecs[4] = '{8'hFF, 1'b0, 2, -1, 33};
        vecs[5] = '{8'h5A, 1'b1, 2, 34, 36};

        rom[0] = '{8'hAE, 1'b1};
        rom[1] = '{8'hD5, 1'b0};
        rom[2] = '{8'h80, 1'b1};
        rom[3] = '{8'hA8, 1'b0};
        rom[4] = '{8'h3F, 1'b1};
        rom[5] = '{8'h8D, 1'b0};
        rom[6] = '{8'h14, 1'b1};
        rom[7] = '{8'hAF, 1'b1};

        resetn = 1'b0;
        start = 1'b0; last = 1'b0; data = 8'h00;
        start1 = 1'b0; last1 = 1'b0; data1 = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_ready", int'(ready), 1);
        check("reset_sclk", int'(sclk), 0);
        check("reset_sdin", int'(sdin), 0);
        check("reset_csn", int'(csn), 1);
        check("reset_ready_div1", int'(ready1), 1);
        check("reset_csn_div1", int'(csn1), 1);
        resetn = 1'b1;
        @(negedge clk);

        // Vector table; vecs 1..2 form a two-byte frame, 3..5 a three-byte frame.
        prev_acc = 0;
        prev_last = 1'b1;
        for (int i = 0; i < 6; i++) begin
            accept_byte(vecs[i].data, vecs[i].last, acc);
            if (!prev_last) check("back_to_back_spacing", acc - prev_acc, 34);
            run_to_ready(acc, rise1, csn_e, rdy_e, rises);
            check("first_rise_edge", rise1, vecs[i].exp_rise1);
            check("sclk_pulses", rises, 8);
            check("csn_rise_edge", csn_e, vecs[i].exp_csn);
            check("ready_edge", rdy_e, vecs[i].exp_rdy);
            prev_acc = acc;
            prev_last = vecs[i].last;
        end
        repeat (4) @(negedge clk);
        check("table_queue_empty", exp_q.size(), 0);

        // Start held while busy, data changed mid-byte: only 0x3C may go out.
        b0 = bytes_seen;
        data = 8'h3C; last = 1'b1; start = 1'b1;
        exp_q.push_back(8'h3C);
        @(posedge clk);
        @(negedge clk);
        acc = cyc;
        repeat (6) @(negedge clk);
        data = 8'hFF;
        repeat (14) @(negedge clk);
        check("busy_ready_low", int'(ready), 0);
        start = 1'b0;
        run_to_ready(acc, rise1, csn_e, rdy_e, rises);
        check("busy_ready_edge", rdy_e, 36);
        repeat (10) @(negedge clk);
        check("busy_one_byte", bytes_seen - b0, 1);
        accept_byte(8'hFF, 1'b1, acc);
        run_to_ready(acc, rise1, csn_e, rdy_e, rises);
        check("after_busy_ready_edge", rdy_e, 36);

        // Async reset after the 3rd SCLK rise of 0xE7, then a clean 0x5A.
        accept_byte(8'hE7, 1'b1, acc);
        p = 1'b0;
        rises = 0;
        for (int n = 0; n < 200 && rises < 3; n++) begin
            @(negedge clk);
            if (sclk && !p) rises++;
            p = sclk;
        end
        check("pre_reset_rises", rises, 3);
        check("pre_reset_sdin", int'(sdin), 1);
        #2 resetn = 1'b0;
        #1;
        check("abort_csn", int'(csn), 1);
        check("abort_sclk", int'(sclk), 0);
        check("abort_sdin", int'(sdin), 0);
        check("abort_ready", int'(ready), 1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        accept_byte(8'h5A, 1'b1, acc);
        run_to_ready(acc, rise1, csn_e, rdy_e, rises);
        check("post_reset_pulses", rises, 8);
        check("post_reset_csn_edge", csn_e, 34);
        check("post_reset_ready_edge", rdy_e, 36);

        // CLK_DIV=1, 0xFF last: SCLK toggles every cycle, SDIN stays 1.
        data1 = 8'hFF; last1 = 1'b1; start1 = 1'b1;
        exp1_q.push_back(8'hFF);
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        acc = cyc;
        check("div1_sdin_at_accept", int'(sdin1), 1);
        rdy1 = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            e = cyc - acc;
            if (e <= 16) begin
                check("div1_sclk", int'(sclk1), e % 2);
                check("div1_sdin", int'(sdin1), 1);
            end
            if (e == 17) check("div1_csn_edge17", int'(csn1), 1);
            if (ready1) begin
                rdy1 = e;
                break;
            end
        end
        check("div1_ready_edge", rdy1, 18);

        // Init-sequencer style command stream fed as fast as ready allows.
        b0 = bytes_seen;
        r0 = csn_rises;
        for (int i = 0; i < 8; i++) begin
            accept_byte(rom[i].data, rom[i].last, acc);
        end
        run_to_ready(acc, rise1, csn_e, rdy_e, rises);
        check("seq_done_ready_edge", rdy_e, 36);
        repeat (4) @(negedge clk);
        check("seq_bytes", bytes_seen - b0, 8);
        check("seq_csn_pulses", csn_rises - r0, 5);

        repeat (5) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_queue1_empty", exp1_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
